// File: rtl/match_sequencer_pkg.sv
// match_sequencer_pkg: shared tug-of-war match types and constants
package match_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        PLAY,
        RESULT,
        OVER
    } state_e;

    localparam logic [1:0] DISP_SCORE  = 2'd0;
    localparam logic [1:0] DISP_TALLY  = 2'd1;
    localparam logic [1:0] DISP_WINNER = 2'd2;

    localparam int ROUNDS_TO_WIN_DEF = 3;

endpackage

// File: rtl/match_sequencer_if.sv
// match_sequencer_if: control and status bundle between game logic and the match sequencer
interface match_sequencer_if;

    logic       slowen;
    logic       start;
    logic       round_end;
    logic       round_right;
    logic       round_tie;
    logic       round_clear;
    logic       play_en;
    logic [2:0] wins_l;
    logic [2:0] wins_r;
    logic       match_over;
    logic       match_right;
    logic [1:0] disp_sel;
    logic       blink;

    modport master (
        output slowen, start, round_end, round_right, round_tie,
        input  round_clear, play_en, wins_l, wins_r, match_over, match_right, disp_sel, blink
    );

    modport slave (
        input  slowen, start, round_end, round_right, round_tie,
        output round_clear, play_en, wins_l, wins_r, match_over, match_right, disp_sel, blink
    );

endinterface

// File: rtl/match_sequencer_tick_timer.sv
// tick_timer: counts slowen ticks and flags the tick that completes TICKS, clear has priority
module tick_timer #(
    parameter int TICKS = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic tick_i,
    output logic done_o
);

    localparam logic [7:0] LAST = 8'(TICKS - 1);

    logic [7:0] cnt_q, cnt_d;

    // terminal flag is taken on the completing tick itself so the owner reacts on that edge
    always_comb begin
        done_o = !clr_i && tick_i && (cnt_q == LAST);
        cnt_d  = clr_i ? '0 : !tick_i ? cnt_q : done_o ? '0 : cnt_q + 8'd1;
    end

    // tick count register
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/match_sequencer.sv
// match_sequencer: best-of-N match controller sequencing rounds, tallies and winner display
module match_sequencer
    import match_sequencer_pkg::*;
#(
    parameter int ROUNDS_TO_WIN = ROUNDS_TO_WIN_DEF,
    parameter int RESULT_TICKS  = 64,
    parameter int BLINK_TICKS   = 8
) (
    input  logic              clk,
    input  logic              rst,
    match_sequencer_if.slave  bus
);

    localparam logic [2:0] RTW = 3'(ROUNDS_TO_WIN);

    state_e     state_q, state_d;
    logic [2:0] wins_l_q, wins_l_d;
    logic [2:0] wins_r_q, wins_r_d;
    logic       round_clear_q, play_en_q, match_over_q;
    logic       match_right_q, match_right_d;
    logic       blink_q, blink_d;
    logic [1:0] disp_sel_q, disp_sel_d;
    logic       res_done, blink_done;
    logic       restart, scored, limit;

    tick_timer #(.TICKS(RESULT_TICKS)) u_result_timer (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q != RESULT),
        .tick_i (bus.slowen),
        .done_o (res_done)
    );

    tick_timer #(.TICKS(BLINK_TICKS)) u_blink_timer (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q != OVER),
        .tick_i (bus.slowen),
        .done_o (blink_done)
    );

    // next match state; round_end wins over start in PLAY because start is never looked at there
    always_comb begin
        restart = (state_q == IDLE || state_q == OVER) && bus.start;
        limit   = (wins_l_q == RTW) || (wins_r_q == RTW);
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = bus.start ? CLEAR : IDLE;
            CLEAR:   state_d = PLAY;
            PLAY:    state_d = bus.round_end ? RESULT : PLAY;
            RESULT:  state_d = !res_done ? RESULT : limit ? OVER : CLEAR;
            OVER:    state_d = bus.start ? CLEAR : OVER;
            default: state_d = IDLE;
        endcase
    end

    // win tallies and the registered output values derived from the next state
    always_comb begin
        scored        = (state_q == PLAY) && bus.round_end && !bus.round_tie;
        wins_l_d      = restart ? '0 :
                        (scored && !bus.round_right && wins_l_q != RTW) ? wins_l_q + 3'd1 : wins_l_q;
        wins_r_d      = restart ? '0 :
                        (scored && bus.round_right && wins_r_q != RTW) ? wins_r_q + 3'd1 : wins_r_q;
        disp_sel_d    = (state_d == PLAY) ? DISP_SCORE : (state_d == OVER) ? DISP_WINNER : DISP_TALLY;
        match_right_d = (state_d != OVER) ? 1'b0 :
                        (state_q == OVER) ? match_right_q : (wins_r_q == RTW);
        blink_d       = (state_d != OVER) ? 1'b0 : blink_done ? !blink_q : blink_q;
    end

    // state, tallies and all outputs are registered so no input reaches an output combinationally
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            wins_l_q      <= '0;
            wins_r_q      <= '0;
            round_clear_q <= 1'b0;
            play_en_q     <= 1'b0;
            match_over_q  <= 1'b0;
            match_right_q <= 1'b0;
            blink_q       <= 1'b0;
            disp_sel_q    <= DISP_TALLY;
        end else begin
            state_q       <= state_d;
            wins_l_q      <= wins_l_d;
            wins_r_q      <= wins_r_d;
            round_clear_q <= (state_d == CLEAR);
            play_en_q     <= (state_d == PLAY);
            match_over_q  <= (state_d == OVER);
            match_right_q <= match_right_d;
            blink_q       <= blink_d;
            disp_sel_q    <= disp_sel_d;
        end
    end

    assign bus.round_clear = round_clear_q;
    assign bus.play_en     = play_en_q;
    assign bus.wins_l      = wins_l_q;
    assign bus.wins_r      = wins_r_q;
    assign bus.match_over  = match_over_q;
    assign bus.match_right = match_right_q;
    assign bus.disp_sel    = disp_sel_q;
    assign bus.blink       = blink_q;

endmodule
